// File: rtl/binary_to_bcd_seq_if.sv
// ---------------------------------------------------------------------------
// binary_to_bcd_seq_if
//   Request/result bundle between a binary producer (score and round counters)
//   and the sequential binary-to-BCD converter that feeds the display muxes.
//   The master owns start/bin. The slave (the converter) owns busy/done and
//   the registered bcd/blank result.
// ---------------------------------------------------------------------------
interface binary_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;

  // Producer side: issues conversion requests and consumes results.
  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  blank
  );

  // Converter side: accepts requests and publishes results.
  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output blank
  );

endinterface : binary_to_bcd_seq_if

// File: rtl/binary_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// binary_to_bcd_seq
//   Sequential shift-and-add-3 (double dabble) binary-to-BCD converter.
//   The converter processes one input bit per clock. It has a start/done
//   handshake. Each result carries a leading-zero blank mask that the
//   seven-segment drivers use to suppress leading zeros.
//
//   Timeline for a start that is accepted at edge 0:
//     edges 1..WIDTH : SHIFT, one add-3/shift step per edge
//     edge WIDTH+1   : DONE publishes bcd/blank and raises done for one cycle
//   After the DONE edge the FSM is already in IDLE. A start that is sampled
//   at the next edge is therefore accepted, which gives WIDTH+2 cycles per
//   result when requests are issued back to back.
//
//   All outputs are registered. No combinational path runs from start or bin
//   to busy, done, bcd or blank.
// ---------------------------------------------------------------------------
module binary_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  binary_to_bcd_seq_if.slave   bus
);

  // -------------------------------------------------------------------------
  // Elaboration-time sanity checks
  // -------------------------------------------------------------------------

  // This function gives the number of decimal digits that 2**width-1 needs.
  // The value is floor(width*log10(2))+1. It is computed with a fixed-point
  // log10(2) so that wide inputs do not overflow a 32-bit power.
  function automatic int min_digits(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("binary_to_bcd_seq: WIDTH must be >= 1 (got %0d)", WIDTH);
    end
    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
      $error("binary_to_bcd_seq: DIGITS=%0d too small for WIDTH=%0d (need %0d)",
             DIGITS, WIDTH, min_digits(WIDTH));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Local parameters and types
  // -------------------------------------------------------------------------

  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int BCD_W  = 4 * DIGITS;

  // On reset, every digit above the ones digit is blanked. This makes an
  // idle display show a single "0".
  localparam logic [DIGITS-1:0] BLANK_RST = DIGITS'({DIGITS{1'b1}} << 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------

  state_e              state_q,   state_d;
  logic [WIDTH-1:0]    shift_q,   shift_d;    // remaining binary bits, MSB first
  logic [BCD_W-1:0]    scratch_q, scratch_d;  // BCD digits under construction
  logic [CNT_W-1:0]    cnt_q,     cnt_d;      // SHIFT steps still to do
  logic [BCD_W-1:0]    bcd_q,     bcd_d;      // last published result
  logic [DIGITS-1:0]   blank_q,   blank_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;

  // Combinational helpers
  logic [BCD_W-1:0]    scratch_adj;           // scratch after the add-3 step
  logic [DIGITS-1:0]   blank_mask;            // leading-zero mask of scratch

  // -------------------------------------------------------------------------
  // Datapath helpers
  // -------------------------------------------------------------------------

  // Before each shift, add 3 to every digit that is >= 5. Doubling that digit
  // then carries correctly into the next decimal digit.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // update, so no path leaves it unassigned and no latch is inferred.
    scratch_adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero mask. blank[i] is set when digit i and every digit above it
  // are zero. The ones digit is never blanked, so a result of 0 shows "0".
  always_comb begin
    logic zero_run;
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run & (scratch_q[4*i +: 4] == 4'd0);
      blank_mask[i] = zero_run;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and register inputs
  // -------------------------------------------------------------------------

  // This block sequences IDLE -> SHIFT -> DONE. It also computes the next
  // value of every register.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    blank_d   = blank_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // start is sampled only here. A request during SHIFT/DONE is dropped.
        if (bus.start) begin
          shift_d   = bus.bin;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        busy_d = 1'b1;
        // {scratch, shift} moves left by one and the binary MSB enters the
        // ones digit. The top digit cannot overflow, because DIGITS is large
        // enough for the input range.
        {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Result and mask update together with done, so bcd/blank never show
        // a partial conversion.
        bcd_d   = scratch_q;
        blank_d = blank_mask;
        done_d  = 1'b1;
        busy_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------

  // This is the state register with synchronous reset. Reset wins over
  // everything, and it aborts a conversion without a done pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      blank_q   <= BLANK_RST;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.bcd   = bcd_q;
  assign bus.blank = blank_q;

endmodule : binary_to_bcd_seq
